arith_unit_seq: RTL and testbench
=================================

# arith_unit_seq

Parametrised, handshaked arithmetic unit: unsigned WIDTH-bit adder plus iterative shift-add multiplier (WIDTH × BWIDTH), selected per transaction by `sel`. It replaces the fixed-width registered add/multiply top. Operands and op-select are captured on a valid/ready handshake. Results are held on a registered output port until the consumer accepts them. The block sits between the operand-issue logic and the result sink in the arithmetic datapath.

## Interface
- `WIDTH`, default 32: A operand width, and B operand width for add.
- `BWIDTH`, default 8: multiplier operand width (low bits of B); must satisfy 1 ≤ BWIDTH ≤ WIDTH.
- `clk` input 1: clock, rising edge.
- `nrst` input 1: reset, synchronous, active-low.
- `in_valid` input 1: operand transaction valid.
- `in_ready` output 1: block can accept; equals (state == IDLE).
- `a` input WIDTH: operand A.
- `b` input WIDTH: operand B. Full width is used for add; only `b[BWIDTH-1:0]` is used for multiply.
- `sel` input 1: 0 = add, 1 = multiply.
- `out_valid` output 1: `result` valid.
- `out_ready` input 1: consumer accepts result.
- `result` output WIDTH+BWIDTH: registered result.
- `busy` output 1: high in any state other than IDLE.

## Operation
- FSM states: IDLE, ADD, MUL, DONE.
- IDLE:
  - `in_ready`=1.
  - On `in_valid`&&`in_ready`, capture `a`, `b`, `sel` into internal registers.
  - Go to ADD if `sel`=0, or MUL if `sel`=1. For MUL, also clear the accumulator and the bit counter.
- ADD (1 cycle):
  - `result` ← zero-extended sum of A + B (see Configuration for the carry bit).
  - Go to DONE.
- MUL (exactly BWIDTH cycles, counter `cnt` = 0..BWIDTH-1):
  - Each cycle, if `B[cnt]`=1, accumulator += A << cnt. Accumulator width is WIDTH+BWIDTH; the product cannot overflow.
  - When `cnt`=BWIDTH-1, load `result` ← final accumulator and go to DONE.
- DONE:
  - `out_valid`=1 and `result` stable.
  - On `out_ready`=1, go to IDLE.
  - While `out_ready`=0, hold indefinitely with `result` unchanged.
- Input capture happens only in IDLE. While `in_ready`=0, `a`/`b`/`sel`/`in_valid` are ignored. There is no overlap of consecutive transactions.
- `result` changes only on entry to DONE. It retains its last value through IDLE.
- Arithmetic is unsigned throughout. Any upper bits not produced by the operation are zero.

## Timing
- Reset (`nrst`=0 at a rising edge):
  - State → IDLE.
  - `result`=0, `out_valid`=0, `busy`=0, accumulator and `cnt` = 0.
  - `in_ready`=1 from the first edge after reset.
- Reset asserted mid-MUL or mid-DONE aborts the transaction: no `out_valid` pulse and no partial result; `result` reads 0.
- Add latency: accept at edge T; `out_valid`=1 after edge T+2.
- Multiply latency: accept at edge T; `out_valid`=1 after edge T+1+BWIDTH.
- Back-to-back throughput:
  - Add: one transaction per 3 cycles with `out_ready` tied high.
  - Multiply: one transaction per BWIDTH+2 cycles with `out_ready` tied high.
- `out_valid` falls on the edge where `out_ready`=1 is sampled in DONE. `in_ready` rises in the same cycle.
- `in_valid` asserted while busy has no effect. It is not queued.

## Configuration
- `ARITH_CARRY_EN` defined:
  - Add result places the carry-out at `result[WIDTH]`, giving `result` = {(BWIDTH-1)'b0, carry, sum}.
- `ARITH_CARRY_EN` undefined:
  - Carry-out is discarded and `result` = {BWIDTH'b0, sum}. This is the legacy behaviour.
- Multiply behaviour is identical in both builds.

## Test plan
- Reset, then WIDTH=32, BWIDTH=8, add A=0x0000_0005, B=0x0000_0007, `out_ready`=1 → `result`=0x00_0000000C, `out_valid` high for one cycle 2 cycles after accept.
- Add A=0xFFFF_FFFF, B=0x0000_0001 → `result`=0x01_0000_0000 with `ARITH_CARRY_EN`, 0x00_0000_0000 without.
- Multiply A=0xFFFF_FFFF, B=0xABCD_12FF (only 0xFF used) → `result`=0xFE_FFFF_FF01, `out_valid` 9 cycles after accept; also A=0x1234_5678, B=0x00 → 0.
- Backpressure: multiply A=3, B=5, hold `out_ready`=0 for 20 cycles → `result`=0x0F held, `in_ready`=0 and a second `in_valid` ignored. On `out_ready`=1, one handshake, then IDLE.
- Reset mid-multiply (`nrst` low at 4th MUL cycle) → `out_valid` never asserts, `result`=0, `busy`=0, `in_ready`=1 next cycle; the following add A=1, B=1 → 2.
- Randomised back-to-back mix of 1000 adds and multiplies with random `out_ready` → every result matches the model, in order, none dropped or duplicated.

Source files
------------

// File: rtl/arith_unit_seq.sv
// -----------------------------------------------------------------------------
// arith_unit_seq
//
// Handshaked sequential arithmetic unit. One transaction at a time is accepted
// on a valid/ready handshake. Each transaction is either an unsigned WIDTH-bit
// add or an iterative shift-add multiply of A (WIDTH bits) by the low BWIDTH
// bits of B. The result is held on a registered port until the consumer takes
// it.
//
// Build option:
//   ARITH_CARRY_EN - when defined, the add carry-out appears at result[WIDTH].
//                    When undefined, the carry is dropped (legacy behaviour).
//                    Multiply behaviour is the same in both builds.
//
// Parameters:
//   WIDTH      operand A width, and operand B width for add (default 32)
//   BWIDTH     multiplier width, taken from b[BWIDTH-1:0] (1 <= BWIDTH <= WIDTH)
//
// Ports:
//   clk        clock, rising edge
//   nrst       synchronous active-low reset
//   in_valid   operand transaction valid
//   in_ready   unit can accept a transaction (idle)
//   a, b       operands (only b[BWIDTH-1:0] is used for multiply)
//   sel        0 = add, 1 = multiply
//   out_valid  result is valid
//   out_ready  consumer accepts the result
//   result     registered result, WIDTH+BWIDTH bits
//   busy       unit is working on or holding a transaction
// -----------------------------------------------------------------------------
module arith_unit_seq #(
    parameter int WIDTH  = 32,
    parameter int BWIDTH = 8
) (
    input  logic                    clk,
    input  logic                    nrst,
    input  logic                    in_valid,
    output logic                    in_ready,
    input  logic [WIDTH-1:0]        a,
    input  logic [WIDTH-1:0]        b,
    input  logic                    sel,
    output logic                    out_valid,
    input  logic                    out_ready,
    output logic [WIDTH+BWIDTH-1:0] result,
    output logic                    busy
);

    localparam int RW    = WIDTH + BWIDTH;
    // A one-bit counter is kept even for BWIDTH == 1 so the register exists.
    localparam int CNT_W = (BWIDTH > 1) ? $clog2(BWIDTH) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(BWIDTH - 1);

    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] ADD  = 2'd1;
    localparam logic [1:0] MUL  = 2'd2;
    localparam logic [1:0] DONE = 2'd3;

    logic [1:0]       state_r;
    logic [1:0]       state_nxt_s;
    logic [WIDTH-1:0] a_r;
    logic [WIDTH-1:0] b_r;
    logic [RW-1:0]    acc_r;
    logic [CNT_W-1:0] cnt_r;
    logic [RW-1:0]    result_r;
    logic             in_ready_r;
    logic             out_valid_r;
    logic             busy_r;

    logic [WIDTH:0]   sum_s;
    logic [RW-1:0]    add_res_s;
    logic             mul_bit_s;
    logic [RW-1:0]    mul_term_s;
    logic [RW-1:0]    acc_nxt_s;
    logic             cnt_last_s;

    // Datapath: adder result and the next partial product of the multiplier.
    always_comb begin
        sum_s = {1'b0, a_r} + {1'b0, b_r};
`ifdef ARITH_CARRY_EN
        add_res_s = RW'(sum_s);
`else
        add_res_s = RW'(sum_s[WIDTH-1:0]);
`endif
        // Select multiplier bit cnt of B; cnt never exceeds BWIDTH-1.
        mul_bit_s = |(b_r & (WIDTH'(1) << cnt_r));
        if (mul_bit_s) begin
            mul_term_s = RW'(a_r) << cnt_r;
        end else begin
            mul_term_s = {RW{1'b0}};
        end
        // Accumulator is WIDTH+BWIDTH wide, so the product cannot overflow.
        acc_nxt_s  = acc_r + mul_term_s;
        cnt_last_s = (cnt_r == CNT_LAST);
    end

    // Next-state logic for the IDLE/ADD/MUL/DONE controller.
    always_comb begin
        state_nxt_s = state_r;
        case (state_r)
            IDLE: begin
                if (in_valid) begin
                    state_nxt_s = sel ? MUL : ADD;
                end else begin
                    state_nxt_s = IDLE;
                end
            end
            ADD: begin
                state_nxt_s = DONE;
            end
            MUL: begin
                if (cnt_last_s) begin
                    state_nxt_s = DONE;
                end else begin
                    state_nxt_s = MUL;
                end
            end
            DONE: begin
                if (out_ready) begin
                    state_nxt_s = IDLE;
                end else begin
                    state_nxt_s = DONE;
                end
            end
            default: begin
                state_nxt_s = IDLE;
            end
        endcase
    end

    // State, handshake flags, operand capture, multiplier iteration and result.
    always_ff @(posedge clk) begin
        if (!nrst) begin
            state_r     <= IDLE;
            a_r         <= {WIDTH{1'b0}};
            b_r         <= {WIDTH{1'b0}};
            acc_r       <= {RW{1'b0}};
            cnt_r       <= {CNT_W{1'b0}};
            result_r    <= {RW{1'b0}};
            in_ready_r  <= 1'b1;
            out_valid_r <= 1'b0;
            busy_r      <= 1'b0;
        end else begin
            state_r <= state_nxt_s;
            // Status flags are decoded from the next state so they are
            // registered yet line up exactly with the state they describe.
            in_ready_r  <= (state_nxt_s == IDLE);
            out_valid_r <= (state_nxt_s == DONE);
            busy_r      <= (state_nxt_s != IDLE);

            case (state_r)
                IDLE: begin
                    // in_ready is high throughout IDLE, so in_valid alone
                    // completes the handshake here.
                    if (in_valid) begin
                        a_r   <= a;
                        b_r   <= b;
                        acc_r <= {RW{1'b0}};
                        cnt_r <= {CNT_W{1'b0}};
                    end else begin
                        a_r <= a_r;
                        b_r <= b_r;
                    end
                end
                ADD: begin
                    result_r <= add_res_s;
                end
                MUL: begin
                    acc_r <= acc_nxt_s;
                    if (cnt_last_s) begin
                        // Final step: publish the accumulator including this
                        // cycle's partial product.
                        result_r <= acc_nxt_s;
                        cnt_r    <= {CNT_W{1'b0}};
                    end else begin
                        cnt_r <= cnt_r + CNT_W'(1);
                    end
                end
                DONE: begin
                    result_r <= result_r;
                end
                default: begin
                    result_r <= result_r;
                end
            endcase
        end
    end

    assign in_ready  = in_ready_r;
    assign out_valid = out_valid_r;
    assign busy      = busy_r;
    assign result    = result_r;

endmodule

// File: tb/tb_arith_unit_seq.sv
// -----------------------------------------------------------------------------
// tb_arith_unit_seq
//
// Self-checking bench for arith_unit_seq (WIDTH=32, BWIDTH=8). Expected
// results come from a plain-arithmetic reference function; the random phase
// keeps a queue of expected results to confirm in-order delivery with no
// drops or duplicates. Honours ARITH_CARRY_EN for the add expectation.
// -----------------------------------------------------------------------------
module tb_arith_unit_seq;

    localparam int W  = 32;
    localparam int BW = 8;

    logic          clk;
    logic          nrst;
    logic          in_valid;
    logic          in_ready;
    logic [W-1:0]  a;
    logic [W-1:0]  b;
    logic          sel;
    logic          out_valid;
    logic          out_ready;
    logic [W+BW-1:0] result;
    logic          busy;

    int n_checks;
    int n_errors;

    arith_unit_seq #(.WIDTH(W), .BWIDTH(BW)) dut (
        .clk       (clk),
        .nrst      (nrst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .a         (a),
        .b         (b),
        .sel       (sel),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .result    (result),
        .busy      (busy)
    );

    // Free-running clock, 10 time-unit period.
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Counts one comparison and reports it when it does not match.
    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    // Advance one cycle; inputs and samples both sit 1 unit after the edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Reference model: plain unsigned arithmetic on 64-bit values.
    function automatic logic [63:0] ref_result(input logic s, input logic [31:0] xa,
                                               input logic [31:0] xb);
        logic [63:0] wa;
        logic [63:0] wb;
        wa = {32'd0, xa};
        wb = {32'd0, xb};
        if (s) begin
            return wa * (wb % (64'd1 << BW));
        end else begin
`ifdef ARITH_CARRY_EN
            return wa + wb;
`else
            return (wa + wb) % (64'd1 << W);
`endif
        end
    endfunction

    // One full transaction: accept, latency, result, optional stall, release.
    task automatic do_txn(input logic s, input logic [31:0] xa, input logic [31:0] xb,
                          input logic [63:0] exp_v, input int stall, input string tag);
        int   w;
        int   lat;
        logic hold_ok;
        sel = s; a = xa; b = xb; in_valid = 1'b1; out_ready = 1'b0;
        w = 0;
        while (!in_ready && w < 50) begin
            tick();
            w++;
        end
        check({tag, "_in_ready"}, in_ready, 1);
        tick();                       // accept edge
        in_valid = 1'b0;
        lat = 1;                      // cycles after the accept cycle
        while (!out_valid && lat < 100) begin
            tick();
            lat++;
        end
        check({tag, "_latency"}, lat, s ? (BW + 1) : 2);
        check({tag, "_result"}, result, exp_v);
        hold_ok = 1'b1;
        for (int i = 0; i < stall; i++) begin
            // A competing request while busy must be ignored.
            in_valid = 1'b1; sel = ~s; a = ~xa; b = ~xb;
            tick();
            hold_ok &= out_valid && !in_ready && busy && (result == exp_v[W+BW-1:0]);
        end
        in_valid = 1'b0;
        if (stall > 0) check({tag, "_hold"}, hold_ok, 1);
        out_ready = 1'b1;
        tick();
        check({tag, "_ovalid_drop"}, out_valid, 0);
        check({tag, "_in_ready_back"}, in_ready, 1);
        out_ready = 1'b0;
        tick();
        check({tag, "_no_ghost"}, {out_valid, busy}, 0);
        check({tag, "_retain"}, result, exp_v);
    endtask

    initial begin
        logic [63:0] q[$];
        logic [63:0] exp_v;
        int accepted;
        int retired;
        int cyc;
        logic seen_valid;

        n_checks = 0; n_errors = 0;
        nrst = 1'b0; in_valid = 1'b0; a = '0; b = '0; sel = 1'b0; out_ready = 1'b0;
        tick(); tick(); tick();
        check("reset_result", result, 0);
        check("reset_out_valid", out_valid, 0);
        check("reset_busy", busy, 0);
        check("reset_in_ready", in_ready, 1);
        nrst = 1'b1;
        tick();

        // Directed cases from the plan.
        do_txn(1'b0, 32'h0000_0005, 32'h0000_0007, 64'h0C, 0, "add_5_7");
`ifdef ARITH_CARRY_EN
        exp_v = 64'h01_0000_0000;
`else
        exp_v = 64'h00_0000_0000;
`endif
        do_txn(1'b0, 32'hFFFF_FFFF, 32'h0000_0001, exp_v, 0, "add_carry");
        do_txn(1'b1, 32'hFFFF_FFFF, 32'hABCD_12FF, 64'hFE_FFFF_FF01, 0, "mul_max");
        do_txn(1'b1, 32'h1234_5678, 32'h0000_0000, 64'h0, 0, "mul_zero");
        do_txn(1'b1, 32'h0000_0003, 32'h0000_0005, 64'h0F, 20, "mul_stall");

        // Reset during the 4th multiply cycle aborts the transaction.
        sel = 1'b1; a = 32'h0000_00FF; b = 32'h0000_00FF; in_valid = 1'b1;
        tick();                       // accept edge
        in_valid = 1'b0;
        tick(); tick(); tick();       // now in the 4th MUL cycle
        nrst = 1'b0;
        tick();
        check("abort_out_valid", out_valid, 0);
        check("abort_result", result, 0);
        check("abort_busy", busy, 0);
        check("abort_in_ready", in_ready, 1);
        nrst = 1'b1;
        seen_valid = 1'b0;
        for (int i = 0; i < 15; i++) begin
            tick();
            seen_valid |= out_valid;
        end
        check("abort_no_valid", seen_valid, 0);
        do_txn(1'b0, 32'h1, 32'h1, 64'h2, 0, "add_after_abort");

        // Randomised back-to-back mix with random backpressure.
        accepted = 0; retired = 0; cyc = 0;
        while ((accepted < 1000 || q.size() > 0) && cyc < 60000) begin
            in_valid = (accepted < 1000) ? ($urandom_range(0, 3) != 0) : 1'b0;
            sel = 1'($urandom_range(0, 1));
            case ($urandom_range(0, 3))
                0:       a = 32'hFFFF_FFFF;
                1:       a = 32'h0000_0000;
                default: a = $urandom;
            endcase
            b = $urandom;
            out_ready = ($urandom_range(0, 2) != 0);
            if (in_valid && in_ready) begin
                q.push_back(ref_result(sel, a, b));
                accepted++;
            end
            if (out_valid && out_ready) begin
                check("rand_queue_nonempty", q.size() > 0, 1);
                if (q.size() > 0) check("rand_result", result, q.pop_front());
                retired++;
            end
            tick();
            cyc++;
        end
        in_valid = 1'b0; out_ready = 1'b0;
        check("rand_accepted", accepted, 1000);
        check("rand_retired", retired, 1000);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
